// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, stop-bit encodings,
// data-bit clamping and frame-length helper (also used by uart_tx_os).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_STOP,
        ST_BREAK
    } rx_state_e;

    localparam logic [1:0] STOP_1   = 2'd0;
    localparam logic [1:0] STOP_1P5 = 2'd1;
    localparam logic [1:0] STOP_2   = 2'd2;

    // Legal data widths are 5..9; anything else falls back to 8.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0] n);
        if (n >= 4'd5 && n <= 4'd9) return n;
        return 4'd8;
    endfunction

    // Frame length in bit times: start + data + parity + stop (1.5 counts as 2).
    function automatic logic [3:0] frame_len(input logic [3:0] nbits,
                                             input logic       par_en,
                                             input logic [1:0] stop);
        logic [3:0] s;
        s = (stop == STOP_1P5 || stop == STOP_2) ? 4'd2 : 4'd1;
        return 4'd1 + nbits + {3'b000, par_en} + s;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rxd synchroniser and baud-tick sample register.
// UART_RX_MAJORITY_EN: bit_o is the 2-of-3 vote over the last three tick
// samples instead of the latest single sample.
module uart_rx_sampler (
    input  logic clk_i,
    input  logic clr_i,
    input  logic tick_i,
    input  logic rxd_i,
    output logic bit_o,
    output logic valid_o
);

    logic [1:0] sync_q;
    logic       smp_q;
    logic       vld_q;

    // Two-flop synchroniser, sample capture on each tick, strobe aligned to the new sample
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sync_q <= 2'b11;
            smp_q  <= 1'b1;
            vld_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
            vld_q  <= tick_i;
            if (tick_i) smp_q <= sync_q[1];
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Two previous tick samples for the vote
    always_ff @(posedge clk_i) begin
        if (clr_i)       hist_q <= 2'b11;
        else if (tick_i) hist_q <= {hist_q[0], smp_q};
    end

    // The vote lags the raw line by one tick, which shifts every decision
    // (start detect included) one tick later with no change to counter reloads.
    assign bit_o = (smp_q & hist_q[0]) | (smp_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign bit_o = smp_q;
`endif

    assign valid_o = vld_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with AXI4-Stream word output, break detection
// and idle-line timeout. Optional macro UART_RX_MAJORITY_EN selects
// 3-sample majority bit decisions inside uart_rx_sampler.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE    = 16,
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned IDLE_CHARS    = 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     En,
    input  logic                     baud_clk,
    output logic [MAX_DATA_BITS-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tkeep,
    output logic                     m_axis_tlast,
    input  logic [3:0]               data_bits,
    input  logic [1:0]               stop_bits,
    input  logic                     parity_en,
    input  logic                     parity_type,
    output logic                     busy,
    output logic                     idle,
    output logic                     overrun_error,
    output logic                     frame_error,
    output logic                     parity_error,
    output logic                     break_detect,
    input  logic                     rxd
);

    localparam int unsigned CNT_W    = $clog2(OVERSAMPLE);
    localparam int unsigned IDLE_MAX = IDLE_CHARS * 13 * OVERSAMPLE;
    localparam int unsigned IDLE_W   = $clog2(IDLE_MAX + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    logic clr;
    logic smp, smp_vld;
    logic [3:0] nbits;
    logic [CNT_W-1:0] stop_reload;
    logic [IDLE_W-1:0] idle_target;

    rx_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0] bitn_q, bitn_d;
    logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d, tdata_q, tdata_d;
    logic acc_q, acc_d, pend_q, pend_d, pbit_q, pbit_d, tvalid_q, tvalid_d;
    logic ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d, brk_q, brk_d, idle_q, idle_d;
    logic act_q, act_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    assign clr   = Rst | ~En;
    assign nbits = clamp_data_bits(data_bits);
    assign idle_target = IDLE_W'(IDLE_CHARS) * IDLE_W'(frame_len(nbits, parity_en, stop_bits))
                       * IDLE_W'(OVERSAMPLE);

    uart_rx_sampler u_sampler (
        .clk_i   (Clk),
        .clr_i   (clr),
        .tick_i  (baud_clk),
        .rxd_i   (rxd),
        .bit_o   (smp),
        .valid_o (smp_vld)
    );

    // Stop-window reload selected by stop_bits (3 behaves as one stop bit)
    always_comb begin
        stop_reload = '0;
        case (stop_bits)
            STOP_1P5: stop_reload = HALF_M1;
            STOP_2:   stop_reload = FULL_M1;
            default:  stop_reload = '0;
        endcase
    end

    // Next-state, datapath and pulse generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitn_d     = bitn_q;
        shreg_d    = shreg_q;
        acc_d      = acc_q;
        pend_d     = pend_q;
        pbit_d     = pbit_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        act_d      = act_q;
        idle_cnt_d = idle_cnt_q;
        ovr_d      = 1'b0;
        fe_d       = 1'b0;
        pe_d       = 1'b0;
        brk_d      = 1'b0;
        idle_d     = 1'b0;

        if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

        if (state_q != ST_IDLE) begin
            idle_cnt_d = '0;
        end else if (smp_vld) begin
            if (!smp)                  idle_cnt_d = '0;
            else if (idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + 1'b1;
        end

        if (act_q && idle_cnt_q >= idle_target) begin
            idle_d = 1'b1;
            act_d  = 1'b0;
        end

        if (smp_vld) begin
            case (state_q)
                ST_IDLE: begin
                    if (!smp) begin
                        state_d = ST_START;
                        cnt_d   = HALF_M1;
                    end
                end
                ST_START: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (smp) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = FULL_M1;
                        acc_d   = parity_type;
                        bitn_d  = '0;
                        shreg_d = '0;
                        pend_d  = 1'b0;
                        pbit_d  = 1'b0;
                    end
                end
                ST_DATA: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
                            if (bitn_q == 4'(i)) shreg_d[i] = smp;
                        end
                        acc_d = acc_q ^ smp;
                        cnt_d = FULL_M1;
                        if (bitn_q == nbits - 4'd1) state_d = parity_en ? ST_PARITY : ST_STOP;
                        else                        bitn_d  = bitn_q + 4'd1;
                    end
                end
                ST_PARITY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        pbit_d  = smp;
                        pend_d  = pend_q | (smp != acc_q);
                        cnt_d   = FULL_M1;
                        state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (smp) begin
                        tdata_d  = shreg_q;
                        tvalid_d = 1'b1;
                        ovr_d    = tvalid_q & ~m_axis_tready;
                        pe_d     = pend_q;
                        act_d    = 1'b1;
                        cnt_d    = stop_reload;
                        state_d  = ST_WAIT_STOP;
                    end else if (shreg_q == '0 && (!parity_en || !pbit_q)) begin
                        brk_d   = 1'b1;
                        state_d = ST_BREAK;
                    end else begin
                        fe_d    = 1'b1;
                        cnt_d   = stop_reload;
                        state_d = ST_WAIT_STOP;
                    end
                end
                ST_WAIT_STOP: begin
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    else             state_d = ST_IDLE;
                end
                ST_BREAK: begin
                    if (smp) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; Rst or !En clears everything
    always_ff @(posedge Clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bitn_q     <= '0;
            shreg_q    <= '0;
            acc_q      <= 1'b0;
            pend_q     <= 1'b0;
            pbit_q     <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            act_q      <= 1'b0;
            idle_cnt_q <= '0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            brk_q      <= 1'b0;
            idle_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitn_q     <= bitn_d;
            shreg_q    <= shreg_d;
            acc_q      <= acc_d;
            pend_q     <= pend_d;
            pbit_q     <= pbit_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            act_q      <= act_d;
            idle_cnt_q <= idle_cnt_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            brk_q      <= brk_d;
            idle_q     <= idle_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tkeep  = 1'b1;
    assign m_axis_tlast  = 1'b1;
    assign busy          = (state_q != ST_IDLE);
    assign idle          = idle_q;
    assign overrun_error = ovr_q;
    assign frame_error   = fe_q;
    assign parity_error  = pe_q;
    assign break_detect  = brk_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os (OVERSAMPLE=16, IDLE_CHARS=2, one baud tick per 4 clocks).
module tb_uart_rx_os;

    localparam int OS = 16;

    typedef enum int {EV_WORD, EV_OVR, EV_FE, EV_PE, EV_BRK, EV_IDLE} ev_e;
    typedef struct {
        ev_e        kind;
        logic [8:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       baud_clk = 1'b0;
    logic       rxd = 1'b1;
    logic       tready = 1'b1;
    logic [8:0] tdata;
    logic       tvalid, tkeep, tlast;
    logic [3:0] data_bits = 4'd8;
    logic [1:0] stop_bits = 2'd0;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       busy, idle, ovr, fe, pe, brk;

    ev_t expq[$];
    int  n_pass = 0;
    int  n_total = 0;
    int  tick_n = 0;
    int  idle_seen = 0;
    int  idle_tick = 0;
    int  busy_fall_tick = 0;
    logic busy_prev = 1'b0;

    uart_rx_os #(.OVERSAMPLE(16), .MAX_DATA_BITS(9), .IDLE_CHARS(2)) dut (
        .Clk           (clk),
        .Rst           (rst),
        .En            (en),
        .baud_clk      (baud_clk),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tkeep  (tkeep),
        .m_axis_tlast  (tlast),
        .data_bits     (data_bits),
        .stop_bits     (stop_bits),
        .parity_en     (parity_en),
        .parity_type   (parity_type),
        .busy          (busy),
        .idle          (idle),
        .overrun_error (ovr),
        .frame_error   (fe),
        .parity_error  (pe),
        .break_detect  (brk),
        .rxd           (rxd)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 baud_clk = 1'b1;
            @(posedge clk);
            #1 baud_clk = 1'b0;
        end
    end

    always @(posedge clk) if (baud_clk) tick_n <= tick_n + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    endtask

    task automatic push(input ev_e k, input logic [8:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        expq.push_back(e);
    endtask

    task automatic observe(input ev_e k, input logic [8:0] d);
        ev_t e;
        if (expq.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got %s (%0h), expected none", k.name(), d);
        end else begin
            e = expq.pop_front();
            check($sformatf("event_kind(exp %s)", e.kind.name()), k, e.kind);
            if (k == EV_WORD && e.kind == EV_WORD) check("tdata", {23'd0, d}, {23'd0, e.data});
        end
    endtask

    // Monitor: every output event is matched against the scoreboard in order
    always @(negedge clk) begin
        if (!rst) begin
            if (tvalid && tready) observe(EV_WORD, tdata);
            if (ovr) observe(EV_OVR, 9'd0);
            if (fe)  observe(EV_FE, 9'd0);
            if (pe)  observe(EV_PE, 9'd0);
            if (brk) observe(EV_BRK, 9'd0);
            if (idle) begin
                idle_seen++;
                idle_tick = tick_n;
                observe(EV_IDLE, 9'd0);
            end
            if (busy_prev && !busy) busy_fall_tick = tick_n;
            busy_prev = busy;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (!baud_clk);
            #1;
        end
    endtask

    // Start bit, LSB-first data, optional parity, one stop bit of value stopv.
    // spike >= 0 inverts that data bit for one tick near its centre;
    // rdy_at >= 0 raises tready that many ticks into the stop bit.
    task automatic send_frame(input logic [8:0] d, input int nb, input logic pen,
                              input logic pbit, input logic stopv,
                              input int spike, input int rdy_at);
        rxd = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < nb; i++) begin
            rxd = d[i];
            if (i == spike) begin
                wait_ticks(8);
                rxd = ~d[i];
                wait_ticks(1);
                rxd = d[i];
                wait_ticks(7);
            end else begin
                wait_ticks(OS);
            end
        end
        if (pen) begin
            rxd = pbit;
            wait_ticks(OS);
        end
        rxd = stopv;
        if (rdy_at >= 0) begin
            wait_ticks(rdy_at);
            tready = 1'b1;
            wait_ticks(OS - rdy_at);
        end else begin
            wait_ticks(OS);
        end
        rxd = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (6) @(posedge clk);
        #1;
        check("reset_tvalid", {31'd0, tvalid}, 32'd0);
        check("reset_tdata", {23'd0, tdata}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_pulses", {27'd0, ovr, fe, pe, brk, idle}, 32'd0);
        rst = 1'b0;

        // No frame yet: a long high line must not raise idle
        wait_ticks(400);
        check("no_idle_without_frame", idle_seen, 0);

        // 8N1 0xA5, then idle timeout 2*10*16 ticks after returning to IDLE
        push(EV_WORD, 9'h0A5);
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        check("busy_after_stop", {31'd0, busy}, 32'd0);
        push(EV_IDLE, 9'd0);
        wait_ticks(360);
        check("idle_seen_once", idle_seen, 1);
        check("idle_delay_ticks", idle_tick - busy_fall_tick, 320);
        wait_ticks(400);
        check("idle_not_repeated", idle_seen, 1);

        // 9 data bits, even parity: good parity, then bad parity
        data_bits = 4'd9; parity_en = 1'b1; parity_type = 1'b0;
        push(EV_WORD, 9'h1C3);
        send_frame(9'h1C3, 9, 1'b1, 1'b1, 1'b1, -1, -1);
        wait_ticks(32);
        push(EV_WORD, 9'h1C3);
        push(EV_PE, 9'd0);
        send_frame(9'h1C3, 9, 1'b1, 1'b0, 1'b1, -1, -1);
        wait_ticks(32);
        // Odd parity: 0x1C3 has five ones, so parity bit 0 is correct
        parity_type = 1'b1;
        push(EV_WORD, 9'h1C3);
        send_frame(9'h1C3, 9, 1'b1, 1'b0, 1'b1, -1, -1);
        wait_ticks(32);

        // 5 data bits, 1.5 stop: word zero-extended
        data_bits = 4'd5; parity_en = 1'b0; stop_bits = 2'd1;
        push(EV_WORD, 9'h015);
        send_frame(9'h015, 5, 1'b0, 1'b0, 1'b1, -1, -1);
        wait_ticks(32);

        // Low stop bit with non-zero data: frame error, no word
        data_bits = 4'd8; stop_bits = 2'd0;
        push(EV_FE, 9'd0);
        send_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, -1, -1);
        wait_ticks(32);
        check("busy_after_frame_error", {31'd0, busy}, 32'd0);

        // Break: 12 bit times low, then a normal frame
        push(EV_BRK, 9'd0);
        rxd = 1'b0;
        wait_ticks(12 * OS);
        rxd = 1'b1;
        wait_ticks(32);
        check("busy_after_break", {31'd0, busy}, 32'd0);
        push(EV_WORD, 9'h03C);
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        wait_ticks(32);

        // 3-tick glitch on the idle line
        rxd = 1'b0;
        wait_ticks(3);
        rxd = 1'b1;
        wait_ticks(32);
        check("busy_after_glitch", {31'd0, busy}, 32'd0);

        // Overrun: 0x11 then 0x22 with tready low
        tready = 1'b0;
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        wait_ticks(32);
        push(EV_OVR, 9'd0);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        wait_ticks(8);
        check("overrun_tvalid", {31'd0, tvalid}, 32'd1);
        check("overrun_tdata", {23'd0, tdata}, 32'h022);
        push(EV_WORD, 9'h022);
        tready = 1'b1;
        wait_ticks(4);
        check("tvalid_after_accept", {31'd0, tvalid}, 32'd0);

        // tready rises on the completing cycle of 0x44: no overrun
        tready = 1'b0;
        push(EV_WORD, 9'h033);
        send_frame(9'h033, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        wait_ticks(32);
        push(EV_WORD, 9'h044);
        send_frame(9'h044, 8, 1'b0, 1'b0, 1'b1, -1, 9);
        wait_ticks(32);

`ifdef UART_RX_MAJORITY_EN
        // Single-tick inverted spike at the centre of bit 3 of 0x5A
        push(EV_WORD, 9'h05A);
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 3, -1);
        wait_ticks(32);
`endif

        wait_ticks(40);
        check("pending_events", expq.size(), 0);
        while (expq.size() > 0) begin
            ev_t e;
            e = expq.pop_front();
            $display("FAIL missing_event: got none, expected %s (%0h)", e.kind.name(), e.data);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised successor UART receiver. Configurable oversampling factor, 5–9 data bits, and optional majority-vote bit sampling. Adds break detection and a programmable idle-line timeout. Sits between the pad-side rxd synchroniser and the AXI4-Stream byte path feeding the AES core; driven by the shared baud-tick generator running at OVERSAMPLE x baud.

Parameters:
OVERSAMPLE, 16, baud_clk ticks per bit; even, 8..32.
MAX_DATA_BITS, 9, widest frame supported; sets tdata width.
IDLE_CHARS, 1, idle timeout in whole frame lengths, 1..15.

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous active-high reset
En  in  1  enable; low behaves as reset
baud_clk  in  1  one-Clk pulse per oversample tick
m_axis  my_axis_if.master  MAX_DATA_BITS  received word; tkeep=1, tlast=1
data_bits  in  4  data bit count 5..9; other values treated as 8
stop_bits  in  2  0: 1 stop, 1: 1.5 stop, 2: 2 stop, 3: treated as 1
parity_en  in  1  1 = parity bit present
parity_type  in  1  1 = odd, 0 = even
busy  out  1  level; state != IDLE
idle  out  1  one-cycle pulse on idle timeout
overrun_error  out  1  one-cycle pulse
frame_error  out  1  one-cycle pulse
parity_error  out  1  one-cycle pulse
break_detect  out  1  one-cycle pulse
rxd  in  1  serial input, asynchronous

Behaviour:
- One clock (Clk). Reset is synchronous and active-high (Rst); Rst or !En has identical effect.
- Reset values: state IDLE, tvalid 0, tdata 0, all pulses 0, busy 0, idle counter 0, activity latch 0. Reset mid-frame abandons the frame with no pulse.
- rxd passes through a 2-flop synchroniser (reset to 1). A sample register captures the synchronised line on every baud_clk.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_STOP, BREAK. The tick counter advances only on baud_clk.
- IDLE: low sample -> START with counter = OVERSAMPLE/2-1.
- START: at count 0, a high sample is a glitch -> IDLE, no frame_error. A low sample -> DATA with counter = OVERSAMPLE-1 and parity accumulator = parity_type.
- DATA: sample LSB first into bit[n]; XOR each bit into the accumulator; reload OVERSAMPLE-1. After bit data_bits-1, go to PARITY if parity_en, else STOP.
- PARITY: mismatch with the accumulator sets a pending parity flag; reload OVERSAMPLE-1; go to STOP.
- STOP, first stop sample:
  - High -> deliver the word, zero-extended to MAX_DATA_BITS; tvalid <= 1; parity_error pulses if the pending flag is set (word still delivered); set the activity latch.
  - Low with all data bits 0 and parity bit 0 (or parity disabled) -> break_detect, no word; go to BREAK.
  - Otherwise low -> frame_error, no word.
  - Reload per stop_bits: 1 stop -> 0, 1.5 stop -> OVERSAMPLE/2-1, 2 stop -> OVERSAMPLE-1. Go to WAIT_STOP.
- WAIT_STOP: at count 0 -> IDLE.
- BREAK: stay until a high sample is seen, then IDLE. No new start bit is accepted while in BREAK.
- Handshake: tvalid is held until tready is high. tdata is stable while tvalid && !tready.
- Overrun: a new word completes while tvalid=1 and tready=0 that cycle -> overrun_error pulse; new word overwrites tdata; tvalid stays 1. If tready=1 in the same cycle, there is no overrun.
- Idle timeout:
  - Frame length F = 1 + data_bits + parity_en + stop, where stop = 1 for 1 stop bit and 2 for 1.5 or 2 stop bits.
  - Target = IDLE_CHARS x F x OVERSAMPLE ticks.
  - Counter increments on baud_clk while in IDLE with a high sample, saturating; it clears otherwise.
  - When it reaches the target and the activity latch is set: idle pulses once and the latch clears.
  - Start-bit detection does not clear the latch. A break does not set it.
- Counter widths are derived from the parameters with $clog2. No truncation at maximum settings: 9 data bits, parity, 2 stop, OVERSAMPLE=32, IDLE_CHARS=15.

Optional Feature:
UART_RX_MAJORITY_EN.
- Defined: each bit decision (start check, data, parity, stop) uses a majority of 3 over the samples on ticks count+1, count, count-1 around the mid-bit tick. The decision is taken at count 0 of a window shifted one tick later; bit timing and latency are otherwise unchanged.
- Undefined: single sample at mid-bit, identical to the base timing above.

Decomposition:
- Package uart_pkg: rx state enum; stop_bits encoding constants (STOP_1, STOP_1P5, STOP_2); data_bits clamp function; frame-length function shared with the future uart_tx_os.
- Sub-module uart_rx_sampler: synchroniser, tick-aligned sample register and optional majority vote. Outputs the sampled bit and a sample-valid strobe.

Test Plan:
- OVERSAMPLE=16, 8N1, send 0xA5, tready=1 -> one tvalid beat with tdata=0x0A5; no error pulses; busy low one tick after the stop bit.
- 9 data bits, even parity, send 0x1C3 with correct parity bit 1 -> tdata=0x1C3; send again with parity bit 0 -> tdata=0x1C3 plus one parity_error pulse.
- 8N1, hold rxd low for 12 bit times, then high -> one break_detect pulse, no tvalid, no frame_error; the next 0x3C frame is received correctly.
- tready=0, send 0x11 then 0x22 -> overrun_error pulse at the second stop bit; tdata=0x022. Repeat with tready=1 on the completing cycle -> no overrun.
- Idle detection:
  - 8N1, IDLE_CHARS=2: after one frame, hold the line high -> idle pulses exactly 2x10x16=320 ticks after re-entering IDLE, once only.
  - With no prior frame -> no idle pulse.
- Glitch and majority:
  - 3-tick low glitch on idle line -> no frame, no errors.
  - With UART_RX_MAJORITY_EN, a 1-tick inverted spike at a data bit centre of 0x5A -> tdata still 0x05A.
